// File: rtl/sample_capture.sv
`default_nettype none
// ============================================================================
// Module      : sample_capture
// Description : WIDTH-channel synchronising sampler with a programmable tick,
//               periodic or change-only capture, and a DEPTH-entry output FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_capture #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4,
  parameter int DIV_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       enable,
  input  logic [DIV_W-1:0]           div,
  input  logic                       mode,
  input  logic                       clr_ovf,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

  logic [WIDTH-1:0]   r_sync1;
  logic [WIDTH-1:0]   r_sync;
  logic [DIV_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_last;
  logic               r_has_last;
  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic               r_overflow;

  logic w_tick;
  logic w_cap;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_tick = enable && (r_cnt == div);
  assign w_cap  = w_tick && (!mode || !r_has_last || (r_sync != r_last));
  assign w_full = (r_count == c_depth);
  assign w_pop  = out_valid && out_ready;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign w_push = w_cap && (!w_full || w_pop);
  assign w_drop = w_cap && w_full && !w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync  <= '0;
    end else begin
      r_sync1 <= in_data;
      r_sync  <= r_sync1;
    end
  end

  // Equality-only wrap: a counter above a freshly lowered div runs to rollover.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!enable) begin
      r_cnt <= '0;
    end else if (r_cnt == div) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last     <= '0;
      r_has_last <= 1'b0;
    end else if (!enable) begin
      r_has_last <= 1'b0;
    end else if (w_cap) begin
      r_last     <= r_sync;
      r_has_last <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= r_sync;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clr_ovf) begin
      r_overflow <= 1'b0;
    end
  end

  assign out_valid = (r_count != '0);
  assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;
  assign count     = r_count;
  assign overflow  = r_overflow;

endmodule
`default_nettype wire
